// File: rtl/axil_reg_if.sv
// AXI4-Lite slave to register-strobe bridge.
// Each AXI-Lite read or write turns into one enable/acknowledge access on the
// register side. The read and write paths are independent, and each allows one
// transaction in flight.
// Optional build macro AXIL_REG_IF_TIMEOUT_EN: if a register access is not
// acknowledged within TIMEOUT cycles, it completes with SLVERR.
module axil_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic [STRB_WIDTH-1:0] reg_wr_strb,
    output logic                  reg_wr_en,
    input  logic                  reg_wr_ack,
    output logic [ADDR_WIDTH-1:0] reg_rd_addr,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    input  logic                  reg_rd_ack
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_REG, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REG, R_RESP} rd_state_t;

    wr_state_t wr_state;
    rd_state_t rd_state;
    logic      aw_held;
    logic      w_held;
    logic      aw_hs;
    logic      w_hs;
    logic      ar_hs;
    logic      wr_expired;
    logic      rd_expired;
    logic      unused_prot;

    // The protection bits carry no meaning for a register bank
    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;

`ifdef AXIL_REG_IF_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    logic [CNT_WIDTH-1:0] wr_cnt;
    logic [CNT_WIDTH-1:0] rd_cnt;

    // An ack in the final waiting cycle takes priority, so expiry only matters without ack
    assign wr_expired = (wr_cnt == CNT_LAST);
    assign rd_expired = (rd_cnt == CNT_LAST);

    // Count unacknowledged write cycles in REG; zero everywhere else so entry starts fresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wr_cnt <= '0;
        else if (wr_state == W_REG && !reg_wr_ack)
            wr_cnt <= wr_cnt + 1'b1;
        else
            wr_cnt <= '0;
    end

    // Count unacknowledged read cycles in REG; zero everywhere else so entry starts fresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_cnt <= '0;
        else if (rd_state == R_REG && !reg_rd_ack)
            rd_cnt <= rd_cnt + 1'b1;
        else
            rd_cnt <= '0;
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign wr_expired     = 1'b0;
    assign rd_expired     = 1'b0;
`endif

    // Write path: collect AW and W in any order, strobe the register, then return B
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state       <= W_IDLE;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= RESP_OKAY;
            reg_wr_en      <= 1'b0;
            reg_wr_addr    <= '0;
            reg_wr_data    <= '0;
            reg_wr_strb    <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        reg_wr_addr    <= s_axil_awaddr;
                        aw_held        <= 1'b1;
                        s_axil_awready <= 1'b0;
                    end else begin
                        s_axil_awready <= !aw_held;
                    end
                    if (w_hs) begin
                        reg_wr_data   <= s_axil_wdata;
                        reg_wr_strb   <= s_axil_wstrb;
                        w_held        <= 1'b1;
                        s_axil_wready <= 1'b0;
                    end else begin
                        s_axil_wready <= !w_held;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        reg_wr_en <= 1'b1;
                        wr_state  <= W_REG;
                    end
                end
                W_REG: begin
                    if (reg_wr_ack) begin
                        reg_wr_en     <= 1'b0;
                        s_axil_bvalid <= 1'b1;
                        s_axil_bresp  <= RESP_OKAY;
                        wr_state      <= W_RESP;
                    end else if (wr_expired) begin
                        reg_wr_en     <= 1'b0;
                        s_axil_bvalid <= 1'b1;
                        s_axil_bresp  <= RESP_SLVERR;
                        wr_state      <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        s_axil_bvalid  <= 1'b0;
                        s_axil_bresp   <= RESP_OKAY;
                        aw_held        <= 1'b0;
                        w_held         <= 1'b0;
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                        wr_state       <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read path: take AR, strobe the register, capture its data and return R
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state       <= R_IDLE;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rresp   <= RESP_OKAY;
            s_axil_rdata   <= '0;
            reg_rd_en      <= 1'b0;
            reg_rd_addr    <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        reg_rd_addr    <= s_axil_araddr;
                        reg_rd_en      <= 1'b1;
                        s_axil_arready <= 1'b0;
                        rd_state       <= R_REG;
                    end else begin
                        s_axil_arready <= 1'b1;
                    end
                end
                R_REG: begin
                    if (reg_rd_ack) begin
                        reg_rd_en     <= 1'b0;
                        s_axil_rdata  <= reg_rd_data;
                        s_axil_rresp  <= RESP_OKAY;
                        s_axil_rvalid <= 1'b1;
                        rd_state      <= R_RESP;
                    end else if (rd_expired) begin
                        reg_rd_en     <= 1'b0;
                        s_axil_rdata  <= '0;
                        s_axil_rresp  <= RESP_SLVERR;
                        s_axil_rvalid <= 1'b1;
                        rd_state      <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axil_rready) begin
                        s_axil_rvalid  <= 1'b0;
                        s_axil_rdata   <= '0;
                        s_axil_rresp   <= RESP_OKAY;
                        s_axil_arready <= 1'b1;
                        rd_state       <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_reg_if.sv
// Testbench for axil_reg_if.
// It uses scoreboard queues: expected register accesses and B/R responses are
// queued as stimulus is issued, and separate processes check them as they
// appear. Build with AXIL_REG_IF_TIMEOUT_EN to cover the timeout cases.
module tb_axil_reg_if;

    logic        clk;
    logic        rst;
    logic [15:0] s_axil_awaddr;
    logic [2:0]  s_axil_awprot;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [15:0] s_axil_araddr;
    logic [2:0]  s_axil_arprot;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;
    logic [15:0] reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strb;
    logic        reg_wr_en;
    logic        reg_wr_ack;
    logic [15:0] reg_rd_addr;
    logic        reg_rd_en;
    logic [31:0] reg_rd_data;
    logic        reg_rd_ack;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          len;
    } wr_exp_t;

    typedef struct {
        logic [15:0] addr;
        int          len;
    } rd_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    wr_exp_t    wr_reg_q[$];
    rd_exp_t    rd_reg_q[$];
    logic [1:0] b_q[$];
    r_exp_t     r_q[$];

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    int          wr_ack_delay = 0;
    int          rd_ack_delay = 0;
    logic [31:0] rd_ack_data  = 32'h0;
    logic        wr_stray     = 1'b0;
    logic        rd_stray     = 1'b0;

    axil_reg_if #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .TIMEOUT   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axil_awaddr (s_axil_awaddr),
        .s_axil_awprot (s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata  (s_axil_wdata),
        .s_axil_wstrb  (s_axil_wstrb),
        .s_axil_wvalid (s_axil_wvalid),
        .s_axil_wready (s_axil_wready),
        .s_axil_bresp  (s_axil_bresp),
        .s_axil_bvalid (s_axil_bvalid),
        .s_axil_bready (s_axil_bready),
        .s_axil_araddr (s_axil_araddr),
        .s_axil_arprot (s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready),
        .s_axil_rdata  (s_axil_rdata),
        .s_axil_rresp  (s_axil_rresp),
        .s_axil_rvalid (s_axil_rvalid),
        .s_axil_rready (s_axil_rready),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_strb   (reg_wr_strb),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_ack    (reg_wr_ack),
        .reg_rd_addr   (reg_rd_addr),
        .reg_rd_en     (reg_rd_en),
        .reg_rd_data   (reg_rd_data),
        .reg_rd_ack    (reg_rd_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("[TB] FAIL %s: got event expected none", name);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (b_q.size() == 0 && r_q.size() == 0 && wr_reg_q.size() == 0 &&
                rd_reg_q.size() == 0 && !s_axil_bvalid && !s_axil_rvalid &&
                !reg_wr_en && !reg_rd_en)
                done = 1'b1;
            else
                cycle();
        end
        if (!done)
            fail_now("wait_idle_budget");
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ctrl"}, {s_axil_awready, s_axil_wready, s_axil_bvalid,
                     s_axil_arready, s_axil_rvalid, reg_wr_en, reg_rd_en,
                     s_axil_bresp, s_axil_rresp}, 64'h0);
        check_output({tag, "_data"}, {s_axil_rdata, reg_wr_data}, 64'h0);
        check_output({tag, "_addr"}, {reg_wr_addr, reg_rd_addr, reg_wr_strb}, 64'h0);
    endtask

    // Register-bank model: checks each strobe against the queue and acks after a set delay
    initial begin
        wr_exp_t cur_wr;
        rd_exp_t cur_rd;
        int      wr_seen;
        int      rd_seen;
        logic    wr_prev;
        logic    rd_prev;
        cur_wr = '{16'h0, 32'h0, 4'h0, 0};
        cur_rd = '{16'h0, 0};
        wr_seen = 0;
        rd_seen = 0;
        wr_prev = 1'b0;
        rd_prev = 1'b0;
        reg_wr_ack  = 1'b0;
        reg_rd_ack  = 1'b0;
        reg_rd_data = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            if (reg_wr_en) begin
                if (!wr_prev) begin
                    wr_seen = 0;
                    if (wr_reg_q.size() == 0) begin
                        fail_now("wr_unexpected");
                        cur_wr = '{16'h0, 32'h0, 4'h0, 0};
                    end else begin
                        cur_wr = wr_reg_q.pop_front();
                        check_output("wr_addr", reg_wr_addr, cur_wr.addr);
                        check_output("wr_data", reg_wr_data, cur_wr.data);
                        check_output("wr_strb", reg_wr_strb, cur_wr.strb);
                    end
                end
                reg_wr_ack = (wr_seen == wr_ack_delay);
                wr_seen++;
            end else begin
                if (wr_prev && cur_wr.len != 0)
                    check_output("wr_en_len", wr_seen, cur_wr.len);
                reg_wr_ack = wr_stray;
            end
            wr_prev = reg_wr_en;

            if (reg_rd_en) begin
                if (!rd_prev) begin
                    rd_seen = 0;
                    if (rd_reg_q.size() == 0) begin
                        fail_now("rd_unexpected");
                        cur_rd = '{16'h0, 0};
                    end else begin
                        cur_rd = rd_reg_q.pop_front();
                        check_output("rd_addr", reg_rd_addr, cur_rd.addr);
                    end
                end
                reg_rd_ack = (rd_seen == rd_ack_delay);
                rd_seen++;
            end else begin
                if (rd_prev && cur_rd.len != 0)
                    check_output("rd_en_len", rd_seen, cur_rd.len);
                reg_rd_ack = rd_stray;
            end
            reg_rd_data = reg_rd_ack && reg_rd_en ? rd_ack_data : 32'hBAD0_BAD0;
            rd_prev = reg_rd_en;
        end
    end

    // Response monitor: pops expected B/R on each handshake and checks R stays stable while stalled
    initial begin
        logic        r_prev_valid;
        logic        r_prev_hs;
        logic [31:0] r_prev_data;
        logic [1:0]  r_prev_resp;
        r_exp_t      r_exp;
        logic [1:0]  b_exp;
        r_prev_valid = 1'b0;
        r_prev_hs    = 1'b0;
        r_prev_data  = 32'h0;
        r_prev_resp  = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (s_axil_bvalid && s_axil_bready) begin
                    if (b_q.size() == 0) begin
                        fail_now("b_unexpected");
                    end else begin
                        b_exp = b_q.pop_front();
                        check_output("bresp", s_axil_bresp, b_exp);
                    end
                end
                if (s_axil_rvalid && r_prev_valid && !r_prev_hs) begin
                    check_output("r_stable_data", s_axil_rdata, r_prev_data);
                    check_output("r_stable_resp", s_axil_rresp, r_prev_resp);
                end
                if (!s_axil_rvalid && r_prev_valid)
                    check_output("rdata_zero", s_axil_rdata, 32'h0);
                if (s_axil_rvalid && s_axil_rready) begin
                    if (r_q.size() == 0) begin
                        fail_now("r_unexpected");
                    end else begin
                        r_exp = r_q.pop_front();
                        check_output("rdata", s_axil_rdata, r_exp.data);
                        check_output("rresp", s_axil_rresp, r_exp.resp);
                    end
                end
            end
            r_prev_valid = s_axil_rvalid;
            r_prev_hs    = s_axil_rvalid && s_axil_rready;
            r_prev_data  = s_axil_rdata;
            r_prev_resp  = s_axil_rresp;
        end
    end

    // Directed stimulus sequence
    initial begin
        rst            = 1'b1;
        s_axil_awaddr  = 16'h0;
        s_axil_awprot  = 3'b0;
        s_axil_awvalid = 1'b0;
        s_axil_wdata   = 32'h0;
        s_axil_wstrb   = 4'h0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b1;
        s_axil_araddr  = 16'h0;
        s_axil_arprot  = 3'b0;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b1;

        repeat (3) cycle();
        check_reset_outputs("rst_init");
        rst = 1'b0;
        cycle();
        check_output("ready_after_init", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

        // AW and W together, ack on first enable cycle
        wr_ack_delay = 0;
        wr_reg_q.push_back('{16'h0010, 32'hDEADBEEF, 4'hF, 1});
        b_q.push_back(2'b00);
        s_axil_awaddr = 16'h0010; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'hDEADBEEF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        cycle();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        check_output("t1_wr_en", reg_wr_en, 1'b1);
        check_output("t1_b_early", s_axil_bvalid, 1'b0);
        cycle();
        check_output("t1_b_latency", s_axil_bvalid, 1'b1);
        wait_idle(50);

        // W two cycles ahead of AW
        wr_ack_delay = 1;
        wr_reg_q.push_back('{16'h0024, 32'hA5A51234, 4'h3, 2});
        b_q.push_back(2'b00);
        s_axil_wdata = 32'hA5A51234; s_axil_wstrb = 4'h3; s_axil_wvalid = 1'b1;
        cycle();
        s_axil_wvalid = 1'b0;
        check_output("t2_wready_low", s_axil_wready, 1'b0);
        check_output("t2_awready_high", s_axil_awready, 1'b1);
        check_output("t2_no_en_a", reg_wr_en, 1'b0);
        cycle();
        check_output("t2_no_en_b", reg_wr_en, 1'b0);
        s_axil_awaddr = 16'h0024; s_axil_awvalid = 1'b1;
        cycle();
        s_axil_awvalid = 1'b0;
        check_output("t2_wr_en", reg_wr_en, 1'b1);
        wait_idle(50);

        // Read with delayed ack and a stalled R channel
        rd_ack_delay = 3;
        rd_ack_data  = 32'h12345678;
        rd_reg_q.push_back('{16'h0100, 4});
        r_q.push_back('{32'h12345678, 2'b00});
        s_axil_rready = 1'b0;
        s_axil_araddr = 16'h0100; s_axil_arvalid = 1'b1;
        cycle();
        s_axil_arvalid = 1'b0;
        check_output("t3_arready_low", s_axil_arready, 1'b0);
        check_output("t3_rd_en", reg_rd_en, 1'b1);
        for (int i = 0; i < 20 && !s_axil_rvalid; i++) cycle();
        check_output("t3_rvalid_seen", s_axil_rvalid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_output("t3_rvalid_hold", s_axil_rvalid, 1'b1);
            cycle();
        end
        s_axil_rready = 1'b1;
        cycle();
        check_output("t3_rvalid_done", s_axil_rvalid, 1'b0);
        check_output("t3_arready_back", s_axil_arready, 1'b1);
        wait_idle(50);

        // Concurrent read and write, acks in the same cycle
        wr_ack_delay = 2;
        rd_ack_delay = 2;
        rd_ack_data  = 32'hCAFEF00D;
        wr_reg_q.push_back('{16'h0040, 32'h11223344, 4'hC, 3});
        rd_reg_q.push_back('{16'h0044, 3});
        b_q.push_back(2'b00);
        r_q.push_back('{32'hCAFEF00D, 2'b00});
        s_axil_awaddr = 16'h0040; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'h11223344; s_axil_wstrb = 4'hC; s_axil_wvalid = 1'b1;
        s_axil_araddr = 16'h0044; s_axil_arvalid = 1'b1;
        cycle();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        check_output("t4_both_en", {reg_wr_en, reg_rd_en}, 2'b11);
        wait_idle(50);

        // Stray acks while idle are ignored
        wr_stray = 1'b1; rd_stray = 1'b1;
        cycle(); cycle();
        wr_stray = 1'b0; rd_stray = 1'b0;
        cycle(); cycle();
        check_output("t5_stray_quiet", {s_axil_bvalid, s_axil_rvalid, reg_wr_en, reg_rd_en}, 4'b0);
        check_output("t5_stray_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

`ifdef AXIL_REG_IF_TIMEOUT_EN
        // Read never acked: enable for 4 cycles, SLVERR with zero data
        rd_ack_delay = 1000;
        rd_reg_q.push_back('{16'h0200, 4});
        r_q.push_back('{32'h0, 2'b10});
        s_axil_araddr = 16'h0200; s_axil_arvalid = 1'b1;
        cycle();
        s_axil_arvalid = 1'b0;
        wait_idle(50);
        rd_stray = 1'b1;
        cycle(); cycle();
        rd_stray = 1'b0;
        cycle(); cycle();
        check_output("t6_no_second_r", s_axil_rvalid, 1'b0);

        // Ack in the last cycle before expiry wins
        rd_ack_delay = 3;
        rd_ack_data  = 32'h55AA55AA;
        rd_reg_q.push_back('{16'h0204, 4});
        r_q.push_back('{32'h55AA55AA, 2'b00});
        s_axil_araddr = 16'h0204; s_axil_arvalid = 1'b1;
        cycle();
        s_axil_arvalid = 1'b0;
        wait_idle(50);

        // Write never acked gives SLVERR
        wr_ack_delay = 1000;
        wr_reg_q.push_back('{16'h0030, 32'h0F0F0F0F, 4'hF, 4});
        b_q.push_back(2'b10);
        s_axil_awaddr = 16'h0030; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'h0F0F0F0F; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        cycle();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        wait_idle(50);
`endif

        // Reset pulsed while a write strobe is outstanding
        wr_ack_delay = 1000;
        wr_reg_q.push_back('{16'h0050, 32'h00000077, 4'h1, 0});
        s_axil_awaddr = 16'h0050; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'h00000077; s_axil_wstrb = 4'h1; s_axil_wvalid = 1'b1;
        cycle();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        check_output("t7_wr_en", reg_wr_en, 1'b1);
        cycle();
        rst = 1'b1;
        #1;
        check_reset_outputs("t7_rst");
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        check_output("t7_ready_after", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
        repeat (5) cycle();
        check_output("t7_no_b", {s_axil_bvalid, reg_wr_en}, 2'b00);

        check_output("sb_empty", b_q.size() + r_q.size() + wr_reg_q.size() + rd_reg_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axil_reg_if.md
Name: axil_reg_if

Overview:
- AXI4-Lite slave to simple register-strobe bridge.
- Sits directly downstream of the AXI4-to-AXI4-Lite adapter; its AXI-Lite slave port connects to that adapter's m_axil_* port.
- Converts each AXI-Lite read or write into a single enable/acknowledge register access that control/status register banks can consume directly.
- Read and write paths are independent; each allows one transaction in flight.

Parameters:
- DATA_WIDTH, 32: register data width in bits (32 or 64).
- ADDR_WIDTH, 16: byte address width in bits.
- STRB_WIDTH, DATA_WIDTH/8: write strobe width.
- TIMEOUT, 4: cycles to wait for ack before an error response. Used only with the optional feature; must be 1 or more.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_awprot  in  3  write protection; accepted and ignored
- s_axil_awvalid/s_axil_awready  in/out  1  AW handshake
- s_axil_wdata  in  DATA_WIDTH  write data
- s_axil_wstrb  in  STRB_WIDTH  write strobes
- s_axil_wvalid/s_axil_wready  in/out  1  W handshake
- s_axil_bresp  out  2  write response
- s_axil_bvalid/s_axil_bready  out/in  1  B handshake
- s_axil_araddr  in  ADDR_WIDTH  read address
- s_axil_arprot  in  3  read protection; accepted and ignored
- s_axil_arvalid/s_axil_arready  in/out  1  AR handshake
- s_axil_rdata  out  DATA_WIDTH  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid/s_axil_rready  out/in  1  R handshake
- reg_wr_addr  out  ADDR_WIDTH  register write address
- reg_wr_data  out  DATA_WIDTH  register write data
- reg_wr_strb  out  STRB_WIDTH  register write strobes
- reg_wr_en  out  1  write request; held until ack
- reg_wr_ack  in  1  write complete
- reg_rd_addr  out  ADDR_WIDTH  register read address
- reg_rd_en  out  1  read request; held until ack
- reg_rd_data  in  DATA_WIDTH  read data; valid when reg_rd_ack=1
- reg_rd_ack  in  1  read complete

Behaviour:

Reset and general
- All outputs are registered.
- While rst=1, every output is 0, including all readies.
- In the first cycle after rst deasserts, awready, wready and arready are 1.
- Assertion of rst mid-transaction aborts it immediately: reg_*_en, bvalid and rvalid go to 0, and no response is issued.

Write FSM states: IDLE, REG, RESP
- IDLE
  - awready = !aw_held and wready = !w_held.
  - AW and W may handshake in either order or in the same cycle; each is latched into a holding register and its ready drops.
  - Once both are held: next cycle enter REG with reg_wr_en=1 and addr/data/strb driven from the holding registers.
  - If AW and W handshake in the same cycle, reg_wr_en=1 on cycle N+1.
- REG
  - On reg_wr_ack=1 (allowed in the first cycle of en), next cycle: reg_wr_en=0, bvalid=1, bresp=2'b00, enter RESP.
- RESP
  - Hold bvalid and bresp until bready=1.
  - Next cycle: bvalid=0, holding flags cleared, readies=1, return to IDLE.
- Minimum AW-to-bvalid latency is 2 cycles. No new AW/W is accepted before the B handshake.

Read FSM states: IDLE, REG, RESP
- IDLE
  - arready=1.
  - AR handshake in cycle N: arready=0, reg_rd_en=1 and reg_rd_addr=araddr in cycle N+1.
- REG
  - On reg_rd_ack: latch reg_rd_data into rdata; next cycle reg_rd_en=0, rvalid=1, rresp=2'b00.
- RESP
  - Hold rdata, rresp and rvalid stable until rready=1, then return to IDLE with arready=1.

Common rules
- reg_*_ack while the corresponding en=0 is ignored.
- Read and write may be in REG simultaneously. There is no ordering between the paths.
- Addresses pass through unmodified; the low bits are not masked.
- rdata is 0 whenever rvalid=0.

Optional Feature:
- Macro: AXIL_REG_IF_TIMEOUT_EN.
- Defined:
  - A per-path counter clears on entry to REG and increments each cycle in REG without ack.
  - When it reaches TIMEOUT with no ack, next cycle: en=0, response issued with resp=2'b10 (SLVERR) and rdata=0.
  - A late ack after the timeout is ignored.
  - An ack arriving in the same cycle the count reaches TIMEOUT wins and gives OKAY.
- Undefined:
  - No counters; TIMEOUT is ignored.
  - REG waits indefinitely for ack; resp is always 2'b00.

Test Plan:
- AW+W same cycle (addr 0x0010, data 0xDEADBEEF, strb 0xF); ack on first en cycle -> reg_wr_en high exactly 1 cycle with those values; bvalid 2 cycles after AW; bresp 00.
- W two cycles before AW (addr 0x0024, strb 0x3) -> wready low after W handshake; reg_wr_en only after AW; single B, bresp 00.
- AR addr 0x0100; ack after 3 cycles with data 0x12345678; rready low 4 cycles -> rvalid, rdata 0x12345678 and rresp 00 stable until rready; arready returns after R handshake.
- Concurrent read and write in REG with acks in the same cycle -> both responses correct; no cross-path corruption.
- With AXIL_REG_IF_TIMEOUT_EN and TIMEOUT=4, never ack a read -> en drops after 4 cycles; rresp 10, rdata 0; a later stray ack causes no second response.
- rst pulsed while reg_wr_en=1 -> all outputs 0 immediately; after release, readies=1 and no bvalid is issued.
